// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, coordinate type and phase decode for the display pipeline.
// Consumed by vga_timing_generator (optional FRAME_COUNT_EN build) and the background generator.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int unsigned VgaHActive = 640;
    localparam int unsigned VgaHFront  = 16;
    localparam int unsigned VgaHSync   = 96;
    localparam int unsigned VgaHBack   = 48;
    localparam int unsigned VgaHTotal  = VgaHActive + VgaHFront + VgaHSync + VgaHBack;

    localparam int unsigned VgaVActive = 480;
    localparam int unsigned VgaVFront  = 10;
    localparam int unsigned VgaVSync   = 2;
    localparam int unsigned VgaVBack   = 33;
    localparam int unsigned VgaVTotal  = VgaVActive + VgaVFront + VgaVSync + VgaVBack;

    localparam int unsigned VgaHSyncFirst = VgaHActive + VgaHFront;
    localparam int unsigned VgaHSyncLast  = VgaHSyncFirst + VgaHSync - 1;
    localparam int unsigned VgaVSyncFirst = VgaVActive + VgaVFront;
    localparam int unsigned VgaVSyncLast  = VgaVSyncFirst + VgaVSync - 1;

    typedef enum logic [1:0] {PhActive, PhFront, PhSync, PhBack} phase_e;

    // Position within one axis: ACTIVE -> FRONT -> SYNC -> BACK.
    function automatic phase_e decode_phase(coord_t c, coord_t active, coord_t front,
                                            coord_t sync);
        if (c < active) begin
            return PhActive;
        end else if (c < active + front) begin
            return PhFront;
        end else if (c < active + front + sync) begin
            return PhSync;
        end
        return PhBack;
    endfunction

endpackage

// File: rtl/pixel_tick_divider.sv
// Divides the system clock into the pixel advance strobe; CLOCK_DIV of 1 or 2.
// The strobe is combinational from the phase flop; the caller registers it.
module pixel_tick_divider #(
    parameter int unsigned CLOCK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic advance_o
);

    localparam logic LastPhase = (CLOCK_DIV == 2) ? 1'b1 : 1'b0;

    logic phase_q, phase_d;

    always_comb begin
        advance_o = (phase_q == LastPhase);
        phase_d   = advance_o ? 1'b0 : ~phase_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: coordinates, visible flag and sync pulses, all registered together.
// Define FRAME_COUNT_EN to add the frameCount / frameStart outputs.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLOCK_DIV   = 2,
    parameter int unsigned H_ACTIVE    = VgaHActive,
    parameter int unsigned H_FRONT     = VgaHFront,
    parameter int unsigned H_SYNC      = VgaHSync,
    parameter int unsigned H_BACK      = VgaHBack,
    parameter int unsigned V_ACTIVE    = VgaVActive,
    parameter int unsigned V_FRONT     = VgaVFront,
    parameter int unsigned V_SYNC      = VgaVSync,
    parameter int unsigned V_BACK      = VgaVBack,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] xOrd,
    output logic [9:0] yOrd,
    output logic       visible,
    output logic       hsync,
    output logic       vsync,
    output logic       pixelTick
`ifdef FRAME_COUNT_EN
    ,
    output logic [7:0] frameCount,
    output logic [0:0] frameStart
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t XMax    = coord_t'(H_TOTAL - 1);
    localparam coord_t YMax    = coord_t'(V_TOTAL - 1);
    localparam coord_t HAct    = coord_t'(H_ACTIVE);
    localparam coord_t HFrnt   = coord_t'(H_FRONT);
    localparam coord_t HSyncW  = coord_t'(H_SYNC);
    localparam coord_t VAct    = coord_t'(V_ACTIVE);
    localparam coord_t VFrnt   = coord_t'(V_FRONT);
    localparam coord_t VSyncW  = coord_t'(V_SYNC);

    logic   advance;
    coord_t x_q, x_d, y_q, y_d;
    logic   visible_q, visible_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   pixel_tick_q, pixel_tick_d;
    phase_e h_phase, v_phase;

    pixel_tick_divider #(
        .CLOCK_DIV (CLOCK_DIV)
    ) u_divider (
        .clk_i     (clock),
        .rst_ni    (reset),
        .advance_o (advance)
    );

    // Flags decode from the next counts so they land on the same edge as the coordinates.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            if (x_q == XMax) begin
                x_d = '0;
                y_d = (y_q == YMax) ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end
        h_phase      = decode_phase(x_d, HAct, HFrnt, HSyncW);
        v_phase      = decode_phase(y_d, VAct, VFrnt, VSyncW);
        visible_d    = (h_phase == PhActive) && (v_phase == PhActive);
        hsync_d      = (h_phase == PhSync) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d      = (v_phase == PhSync) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        pixel_tick_d = advance;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q          <= XMax;
            y_q          <= YMax;
            visible_q    <= 1'b0;
            hsync_q      <= ~SYNC_ACTIVE;
            vsync_q      <= ~SYNC_ACTIVE;
            pixel_tick_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            visible_q    <= visible_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            pixel_tick_q <= pixel_tick_d;
        end
    end

    assign xOrd      = x_q;
    assign yOrd      = y_q;
    assign visible   = visible_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign pixelTick = pixel_tick_q;

`ifdef FRAME_COUNT_EN
    logic       started_q, started_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       frame_start_q, frame_start_d;

    // The wrap out of the reset position opens frame 0, so it is not counted.
    always_comb begin
        frame_start_d = advance && (x_d == '0) && (y_d == '0);
        started_d     = started_q | advance;
        frame_count_d = frame_count_q;
        if (frame_start_d && started_q) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            started_q     <= 1'b0;
            frame_count_q <= 8'd0;
            frame_start_q <= 1'b0;
        end else begin
            started_q     <= started_d;
            frame_count_q <= frame_count_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frameCount = frame_count_q;
    assign frameStart = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three instances (640x480 div 2, 640x480 div 1, tiny raster div 2)
// checked every cycle against a tick-count model, plus directed literal checks.
module tb_vga_timing_generator;

    logic clock = 1'b0;
    logic reset = 1'b0;
    bit   run   = 1'b0;
    int   e     = 0;
    int   ncheck = 0;
    int   npass  = 0;

    logic [9:0] xa, ya, xb, yb, xc, yc;
    logic visa, hsa, vsa, tka, visb, hsb, vsb, tkb, visc, hsc, vsc, tkc;
`ifdef FRAME_COUNT_EN
    logic [7:0] fca, fcb, fcc;
    logic [0:0] fsa, fsb, fsc;
`endif

    always #10 clock = ~clock;

    vga_timing_generator u_a (
        .clock (clock), .reset (reset), .xOrd (xa), .yOrd (ya), .visible (visa),
        .hsync (hsa), .vsync (vsa), .pixelTick (tka)
`ifdef FRAME_COUNT_EN
        , .frameCount (fca), .frameStart (fsa)
`endif
    );

    vga_timing_generator #(.CLOCK_DIV (1)) u_b (
        .clock (clock), .reset (reset), .xOrd (xb), .yOrd (yb), .visible (visb),
        .hsync (hsb), .vsync (vsb), .pixelTick (tkb)
`ifdef FRAME_COUNT_EN
        , .frameCount (fcb), .frameStart (fsb)
`endif
    );

    vga_timing_generator #(
        .CLOCK_DIV (2), .H_ACTIVE (12), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
        .V_ACTIVE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (2), .SYNC_ACTIVE (1'b1)
    ) u_c (
        .clock (clock), .reset (reset), .xOrd (xc), .yOrd (yc), .visible (visc),
        .hsync (hsc), .vsync (vsc), .pixelTick (tkc)
`ifdef FRAME_COUNT_EN
        , .frameCount (fcc), .frameStart (fsc)
`endif
    );

    // Rising edges since reset release; the whole model is a function of this.
    always @(posedge clock or negedge reset) begin
        if (!reset) e <= 0;
        else        e <= e + 1;
    end

    typedef struct {
        int x; int y; int vis; int hs; int vs; int tk; int fc; int fs;
    } exp_t;

    function automatic exp_t model(int edges, int div, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb, int sa);
        exp_t m;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int k  = (div == 2) ? edges / 2 : edges;
        int p;
        m.tk = (edges > 0 && (div == 1 || edges % 2 == 0)) ? 1 : 0;
        if (k == 0) begin
            m.x = ht - 1; m.y = vt - 1; m.vis = 0; m.hs = 1 - sa; m.vs = 1 - sa;
            m.fc = 0; m.fs = 0;
        end else begin
            p     = (k - 1) % (ht * vt);
            m.x   = p % ht;
            m.y   = p / ht;
            m.vis = (m.x < ha && m.y < va) ? 1 : 0;
            m.hs  = (m.x >= ha + hf && m.x < ha + hf + hsw) ? sa : 1 - sa;
            m.vs  = (m.y >= va + vf && m.y < va + vf + vsw) ? sa : 1 - sa;
            m.fc  = ((k - 1) / (ht * vt)) % 256;
            m.fs  = (m.tk == 1 && p == 0) ? 1 : 0;
        end
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        ncheck++;
        if (act == req) npass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t edge=%0d)", name, act, req, $time, e);
    endtask

    task automatic cmp_dut(input string tag, input exp_t m, input int x, input int y,
                           input int vis, input int hs, input int vs, input int tk,
                           input int fc, input int fs);
        chk({tag, ".xOrd"}, x, m.x);
        chk({tag, ".yOrd"}, y, m.y);
        chk({tag, ".visible"}, vis, m.vis);
        chk({tag, ".hsync"}, hs, m.hs);
        chk({tag, ".vsync"}, vs, m.vs);
        chk({tag, ".pixelTick"}, tk, m.tk);
`ifdef FRAME_COUNT_EN
        chk({tag, ".frameCount"}, fc, m.fc);
        chk({tag, ".frameStart"}, fs, m.fs);
`endif
    endtask

    task automatic check_all();
        exp_t ma, mb, mc;
        int fa = 0, sa = 0, fb = 0, sb = 0, fc = 0, sc = 0;
        ma = model(e, 2, 640, 16, 96, 48, 480, 10, 2, 33, 0);
        mb = model(e, 1, 640, 16, 96, 48, 480, 10, 2, 33, 0);
        mc = model(e, 2, 12, 2, 3, 3, 6, 1, 2, 2, 1);
`ifdef FRAME_COUNT_EN
        fa = int'(fca); sa = int'(fsa); fb = int'(fcb); sb = int'(fsb);
        fc = int'(fcc); sc = int'(fsc);
`endif
        cmp_dut("A", ma, int'(xa), int'(ya), int'(visa), int'(hsa), int'(vsa), int'(tka), fa, sa);
        cmp_dut("B", mb, int'(xb), int'(yb), int'(visb), int'(hsb), int'(vsb), int'(tkb), fb, sb);
        cmp_dut("C", mc, int'(xc), int'(yc), int'(visc), int'(hsc), int'(vsc), int'(tkc), fc, sc);
    endtask

    always @(negedge clock) begin
        if (run) check_all();
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_hs_ticks = 0, a_first_invis = -1, a_hs_first = -1, a_hs_last = -1;
        int b_prev = -1, b_period = -1;
        int c_prev = -1, c_period = -1, c_vs_ticks = 0, c_vis_bad = 0;
        int c_fs_pulses = 0, c_fc_f2 = -1;

        run = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        @(negedge clock);
        chk("A.edge1_tick", int'(tka), 0);
        chk("A.edge1_x", int'(xa), 799);
        chk("B.edge1_tick", int'(tkb), 1);
        chk("B.edge1_x", int'(xb), 0);
        @(negedge clock);
        chk("A.edge2_tick", int'(tka), 1);
        chk("A.edge2_x", int'(xa), 0);
        chk("A.edge2_y", int'(ya), 0);
        chk("A.edge2_visible", int'(visa), 1);
        repeat (2) @(negedge clock);
        chk("A.edge4_x", int'(xa), 1);

        for (int i = 0; i < 2000 && e < 1602; i++) begin
            @(negedge clock);
            if (tka && !hsa) begin
                a_hs_ticks++;
                if (a_hs_first < 0) a_hs_first = int'(xa);
                a_hs_last = int'(xa);
            end
            if (!visa && ya == 10'd0 && a_first_invis < 0) a_first_invis = int'(xa);
            if (tkb && xb == 10'd0) begin
                if (b_prev >= 0) b_period = e - b_prev;
                b_prev = e;
            end
            if (tkc && xc == 10'd0 && yc == 10'd0) begin
                if (c_prev >= 0 && c_period < 0) c_period = e - c_prev;
                c_prev = e;
            end
            if (tkc && vsc && e >= 442 && e < 882) c_vs_ticks++;
            if (visc && yc >= 10'd6) c_vis_bad++;
`ifdef FRAME_COUNT_EN
            if (fsc == 1'b1) c_fs_pulses++;
            if (e == 442) c_fc_f2 = int'(fcc);
`endif
        end
        chk("A.hsync_low_ticks", a_hs_ticks, 96);
        chk("A.hsync_first_x", a_hs_first, 656);
        chk("A.hsync_last_x", a_hs_last, 751);
        chk("A.visible_drop_x", a_first_invis, 640);
        chk("A.line_wrap_x", int'(xa), 0);
        chk("A.line_wrap_y", int'(ya), 1);
        chk("B.line_period_clocks", b_period, 800);
        chk("C.frame_period_clocks", c_period, 440);
        chk("C.vsync_ticks_per_frame", c_vs_ticks, 40);
        chk("C.visible_in_vblank", c_vis_bad, 0);
`ifdef FRAME_COUNT_EN
        chk("C.frame_start_pulses", c_fs_pulses, 3);
        chk("C.frame_count_frame2", c_fc_f2, 1);
`endif

        // Random extra run length before the mid-line reset, then reset at A=(300,1).
        repeat ($urandom_range(1, 7) * 2) @(negedge clock);
        for (int i = 0; i < 2000 && e < 2202; i++) @(negedge clock);
        chk("A.pre_reset_x", int'(xa), 300);
        chk("A.pre_reset_y", int'(ya), 1);
        #5 reset = 1'b0;
        #1;
        chk("A.async_reset_x", int'(xa), 799);
        chk("A.async_reset_y", int'(ya), 524);
        chk("A.async_reset_visible", int'(visa), 0);
        chk("A.async_reset_hsync", int'(hsa), 1);
        chk("A.async_reset_tick", int'(tka), 0);
        check_all();

        repeat ($urandom_range(2, 5)) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("A.restart_x", int'(xa), 0);
        chk("A.restart_y", int'(ya), 0);
        chk("A.restart_tick", int'(tka), 1);
        repeat (300 + $urandom_range(0, 100)) @(negedge clock);

        run = 1'b0;
        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
